// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the instruction-fetch and data ports, one transaction at a time.
// Data has priority; instruction fetch wins once after STARVE_LIMIT consecutive data grants.
module sram_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state,
  output logic        dbg_owner,
  output logic [3:0]  dbg_starve_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        grant_inst;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    req_d      = req_q;
    wr_d       = wr_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    grant_inst = inst_req && (!data_req || (starve_q == LIMIT));
    case (state_q)
      S_IDLE: begin
        if (inst_req || data_req) begin
          state_d = S_ADDR;
          req_d   = 1'b1;
          if (grant_inst) begin
            owner_d  = OWN_INST;
            wr_d     = 1'b0;
            size_d   = 2'd2;
            addr_d   = inst_addr;
            wdata_d  = 32'd0;
            starve_d = 4'd0;
          end else begin
            owner_d = OWN_DATA;
            wr_d    = data_wr;
            size_d  = data_size;
            addr_d  = data_addr;
            wdata_d = data_wdata;
            // Only a data grant that bypasses a waiting fetch counts toward starvation.
            if (inst_req) starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
            else          starve_d = 4'd0;
          end
        end
      end
      S_ADDR: begin
        if (bus_addr_ok) begin
          req_d   = 1'b0;
          state_d = bus_data_ok ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bus_data_ok) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_INST;
      starve_q <= 4'd0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  logic addr_hs, data_hs;
  assign addr_hs = (state_q == S_ADDR) && bus_addr_ok;
  // data_ok counts in ADDR only alongside addr_ok (zero-latency slave); in IDLE it is ignored.
  assign data_hs = ((state_q == S_ADDR) && bus_addr_ok && bus_data_ok) ||
                   ((state_q == S_DATA) && bus_data_ok);

  assign inst_addr_ok = addr_hs && (owner_q == OWN_INST);
  assign inst_data_ok = data_hs && (owner_q == OWN_INST);
  assign data_addr_ok = addr_hs && (owner_q == OWN_DATA);
  assign data_data_ok = data_hs && (owner_q == OWN_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  assign bus_req   = req_q;
  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  assign busy           = (state_q != S_IDLE);
  assign dbg_state      = state_q;
  assign dbg_owner      = owner_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: hand sequences for single transactions and reset,
// plus a cycle table for arbitration order and starvation.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        busy;
  logic [1:0]  dbg_state;
  logic        dbg_owner;
  logic [3:0]  dbg_starve_cnt;

  int n_cmp = 0;
  int n_err = 0;

  sram_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .busy(busy), .dbg_state(dbg_state), .dbg_owner(dbg_owner), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       ireq, dreq, bao, bdo;
    logic [11:0] exp;  // {busy, bus_req, iaok, idok, daok, ddok, state[1:0], starve[3:0]}
  } vec_t;
  vec_t vec[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic ireq, dreq, bao, bdo, busy_e, breq_e, iaok, idok, daok, ddok,
                     input logic [1:0] st, input logic [3:0] sc);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.bao = bao; v.bdo = bdo;
    v.exp  = {busy_e, breq_e, iaok, idok, daok, ddok, st, sc};
    vec.push_back(v);
  endtask

  initial begin
    resetn = 1'b0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;

    // Reset values
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_bus_fields", {27'd0, bus_wr, bus_size, 2'd0}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    chk("rst_state_owner_cnt", {25'd0, dbg_state, dbg_owner, dbg_starve_cnt}, 0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    // Instruction read, addr_ok one cycle after bus_req, data_ok two cycles later
    inst_req = 1; inst_addr = 32'hBFC00000;
    #1 chk("ir_idle_busy", 32'(busy), 0);
    step();
    #1;
    chk("ir_bus_req", 32'(bus_req), 1);
    chk("ir_bus_wr", 32'(bus_wr), 0);
    chk("ir_bus_size", 32'(bus_size), 2);
    chk("ir_bus_addr", bus_addr, 32'hBFC00000);
    chk("ir_bus_wdata", bus_wdata, 0);
    chk("ir_wait_aok", 32'(inst_addr_ok), 0);
    step();
    bus_addr_ok = 1;
    #1 chk("ir_oks_at_addr", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'b1000);
    step();
    inst_req = 0; bus_addr_ok = 0;
    #1 chk("ir_data_phase", {29'd0, busy, bus_req, inst_data_ok}, 32'b100);
    step();
    bus_data_ok = 1; bus_rdata = 32'h3C1D8000;
    #1 chk("ir_oks_at_data", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'b0100);
    chk("ir_rdata", inst_rdata, 32'h3C1D8000);
    step();
    bus_data_ok = 0;
    #1 chk("ir_done_busy", {30'd0, busy, bus_req}, 0);

    // Data byte write
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h80001003; data_wdata = 32'h000000AB;
    step();
    #1;
    chk("dw_bus_wr", 32'(bus_wr), 1);
    chk("dw_bus_size", 32'(bus_size), 0);
    chk("dw_bus_addr", bus_addr, 32'h80001003);
    chk("dw_bus_wdata", bus_wdata, 32'h000000AB);
    bus_addr_ok = 1;
    #1 chk("dw_oks_at_addr", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'b0010);
    step();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #1 chk("dw_oks_at_data", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'b0001);
    step();
    bus_data_ok = 0;
    #1 chk("dw_done", {27'd0, busy, dbg_starve_cnt}, 0);

    // Cycle table: simultaneous requests, then starvation with a zero-latency slave
    //   ireq dreq bao bdo | busy breq iaok idok daok ddok state starve
    add(1,1,0,0, 0,0,0,0,0,0, 2'd0, 4'd0);
    add(1,1,1,0, 1,1,0,0,1,0, 2'd1, 4'd1);
    add(1,0,0,0, 1,0,0,0,0,0, 2'd2, 4'd1);
    add(1,0,1,1, 1,0,0,0,0,1, 2'd2, 4'd1);
    add(1,0,0,0, 0,0,0,0,0,0, 2'd0, 4'd1);
    add(1,0,1,1, 1,1,1,1,0,0, 2'd1, 4'd0);
    add(0,0,0,1, 0,0,0,0,0,0, 2'd0, 4'd0);
    for (int k = 0; k < 6; k++) begin
      logic [3:0] s_idle, s_addr;
      logic       inst_turn;
      s_idle    = (k < 5) ? 4'(k) : 4'd0;
      inst_turn = (k == 4);
      s_addr    = inst_turn ? 4'd0 : s_idle + 4'd1;
      add(1,1,1,1, 0,0,0,0,0,0, 2'd0, s_idle);
      add(1,1,1,1, 1,1, inst_turn, inst_turn, !inst_turn, !inst_turn, 2'd1, s_addr);
    end
    add(0,0,0,0, 0,0,0,0,0,0, 2'd0, 4'd1);

    for (int i = 0; i < vec.size(); i++) begin
      logic [11:0] act;
      inst_req = vec[i].ireq; data_req = vec[i].dreq;
      bus_addr_ok = vec[i].bao; bus_data_ok = vec[i].bdo;
      #1;
      act = {busy, bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
             dbg_state, dbg_starve_cnt};
      chk($sformatf("row%0d", i), 32'(act), 32'(vec[i].exp));
      step();
    end

    // Reset during DATA abandons the transaction
    data_wr = 0; data_req = 1;
    step();
    bus_addr_ok = 1;
    #1 chk("rm_addr_ok", 32'(data_addr_ok), 1);
    step();
    data_req = 0; bus_addr_ok = 0;
    #1 chk("rm_in_data", {30'd0, busy, bus_req}, 32'b10);
    resetn = 0;
    bus_data_ok = 1;
    #1 chk("rm_reset_now", {28'd0, busy, bus_req, data_data_ok, inst_data_ok}, 0);
    step();
    resetn = 1; bus_data_ok = 0;
    #1 chk("rm_after_release", {30'd0, busy, bus_req}, 0);
    inst_req = 1; inst_addr = 32'h00400000;
    step();
    #1 chk("rm_new_grant", {31'd0, bus_req}, 1);
    chk("rm_new_addr", bus_addr, 32'h00400000);
    bus_addr_ok = 1; bus_data_ok = 1;
    #1 chk("rm_new_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'b1100);
    step();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    #1 chk("rm_new_done", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
